// File: rtl/ins_ctrl.sv
// Instruction sequencer: fetch/decode/execute controller issuing bus, register and ALU strobes.
// Outputs decode from state and opcode only, so a falling rst clears every strobe without a clock edge.
module ins_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] ins,
  output logic [1:0] fetch,
  output logic       pc_ena,
  output logic       addr_sel,
  output logic       rom_sel,
  output logic       ram_sel,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic       reg_src,
  output logic       alu_ena,
  output logic       acc_ena,
  output logic       halted
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDO = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_LDM = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_DEC  = 3'd2,
    S_F2   = 3'd3,
    S_EX   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   two_byte;

  // Opcodes that carry an operand byte and so need the F2 fetch.
  assign two_byte = (ins == OP_LDO) || (ins == OP_LDA) ||
                    (ins == OP_STO) || (ins == OP_PRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fetch    = 2'b00;
    pc_ena   = 1'b0;
    addr_sel = 1'b0;
    rom_sel  = 1'b0;
    ram_sel  = 1'b0;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    reg_rd   = 1'b0;
    reg_wr   = 1'b0;
    reg_src  = 1'b0;
    alu_ena  = 1'b0;
    acc_ena  = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = en ? S_F1 : S_IDLE;
      end
      S_F1: begin
        fetch   = 2'b01;
        rom_sel = 1'b1;
        pc_ena  = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        state_d = two_byte ? S_F2 : S_EX;
      end
      S_F2: begin
        fetch   = 2'b10;
        rom_sel = 1'b1;
        pc_ena  = 1'b1;
        state_d = S_EX;
      end
      S_EX: begin
        unique case (ins)
          OP_NOP: ;
          OP_LDO: begin
            addr_sel = 1'b1;
            rom_sel  = 1'b1;
            reg_wr   = 1'b1;
          end
          OP_LDA: begin
            addr_sel = 1'b1;
            ram_sel  = 1'b1;
            ram_rd   = 1'b1;
            reg_wr   = 1'b1;
          end
          OP_STO: begin
            addr_sel = 1'b1;
            reg_rd   = 1'b1;
            ram_sel  = 1'b1;
            ram_wr   = 1'b1;
          end
          OP_PRE: begin
            addr_sel = 1'b1;
            rom_sel  = 1'b1;
            acc_ena  = 1'b1;
          end
          OP_ADD: begin
            reg_rd  = 1'b1;
            alu_ena = 1'b1;
            acc_ena = 1'b1;
          end
          OP_LDM: begin
            reg_wr  = 1'b1;
            reg_src = 1'b1;
          end
          OP_HLT: ;
          default: ;
        endcase
        // en is only consulted here and in IDLE, so dropping it never aborts an instruction.
        if (ins == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = en ? S_F1 : S_IDLE;
        end
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ins_ctrl.sv
// Bench for ins_ctrl: directed scenarios followed by random opcodes, en and resets against a cycle-list model.
module tb_ins_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] ins;
  logic [1:0] fetch;
  logic       pc_ena, addr_sel, rom_sel, ram_sel, ram_rd, ram_wr;
  logic       reg_rd, reg_wr, reg_src, alu_ena, acc_ena, halted;

  int errors = 0;
  int checks = 0;

  ins_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .ins(ins),
    .fetch(fetch), .pc_ena(pc_ena), .addr_sel(addr_sel), .rom_sel(rom_sel),
    .ram_sel(ram_sel), .ram_rd(ram_rd), .ram_wr(ram_wr), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .reg_src(reg_src), .alu_ena(alu_ena), .acc_ena(acc_ena),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Model: list of expected output words for the remaining cycles of the current instruction.
  logic [13:0] exp_q[$];
  logic [2:0]  op_q[$];
  logic [2:0]  cur_op;
  bit          halted_m = 1'b0;
  bit          new_instr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // {fetch, pc_ena, addr_sel, rom_sel, ram_sel, ram_rd, ram_wr, reg_rd, reg_wr, reg_src, alu_ena, acc_ena, halted}
  function automatic logic [13:0] mk(input logic [1:0] f, input logic pc, input logic as,
                                     input logic rom, input logic ram, input logic rrd,
                                     input logic rwr, input logic grd, input logic gwr,
                                     input logic src, input logic alu, input logic acc,
                                     input logic hlt);
    return {f, pc, as, rom, ram, rrd, rwr, grd, gwr, src, alu, acc, hlt};
  endfunction

  function automatic logic [13:0] ex_word(input logic [2:0] op);
    case (op)
      3'd1:    return mk(2'b00, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); // LDO
      3'd2:    return mk(2'b00, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0); // LDA
      3'd3:    return mk(2'b00, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0); // STO
      3'd4:    return mk(2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); // PRE
      3'd5:    return mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0); // ADD
      3'd6:    return mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); // LDM
      default: return 14'd0;                                         // NOP, HLT
    endcase
  endfunction

  function automatic logic [13:0] actual();
    return {fetch, pc_ena, addr_sel, rom_sel, ram_sel, ram_rd, ram_wr,
            reg_rd, reg_wr, reg_src, alu_ena, acc_ena, halted};
  endfunction

  function automatic logic [13:0] expected();
    if (halted_m) return 14'd1;
    if (exp_q.size() == 0) return 14'd0;
    return exp_q[0];
  endfunction

  task automatic start_instr();
    if (op_q.size() > 0) cur_op = op_q.pop_front();
    else cur_op = 3'($urandom_range(0, 7));
    exp_q.push_back(mk(2'b01, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(14'd0);
    if (cur_op >= 3'd1 && cur_op <= 3'd4)
      exp_q.push_back(mk(2'b10, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ex_word(cur_op));
    new_instr = 1'b1;
  endtask

  task automatic advance();
    new_instr = 1'b0;
    if (halted_m) return;
    if (exp_q.size() == 0) begin
      if (en) start_instr();
    end else begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        if (cur_op == 3'd7) halted_m = 1'b1;
        else if (en) start_instr();
      end
    end
  endtask

  // One clock: compare at negedge, optional async reset pulse, drive en, then step the model.
  task automatic cyc(input logic en_v, input bit do_rst);
    @(negedge clk);
    check("outputs", 32'(actual()), 32'(expected()));
    check("fetch_never_11", 32'(fetch == 2'b11), 32'd0);
    check("ram_rd_wr_excl", 32'(ram_rd & ram_wr), 32'd0);
    check("rom_ram_excl", 32'(rom_sel & ram_sel), 32'd0);
    if (do_rst) begin
      rst = 1'b0;
      #1;
      check("rst_async_ram_wr", 32'(ram_wr), 32'd0);
      check("rst_async_outputs", 32'(actual()), 32'd0);
      exp_q.delete();
      halted_m = 1'b0;
      #1 rst = 1'b1;
    end
    en = en_v;
    @(posedge clk);
    advance();
    #1;
    if (new_instr) ins = cur_op;
  endtask

  initial begin
    bit done;
    rst = 1'b0;
    en  = 1'b1;
    ins = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(actual()), 32'd0);
    en  = 1'b0;
    rst = 1'b1;

    // NOP, LDA, STO, ADD back-to-back, then PRE with en dropped from its F2 onward.
    op_q = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd4};
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (cur_op == 3'd4 && exp_q.size() == 2 && op_q.size() == 0) done = 1'b1;
      else cyc(1'b1, 1'b0);
    end
    if (!done) check("timeout_pre_f2", 32'd1, 32'd0);
    repeat (8) cyc(1'b0, 1'b0);
    check("idle_after_en_drop", 32'(exp_q.size()), 32'd0);

    // HLT, then toggling en must not leave HALT; reset pulse returns to IDLE.
    op_q.push_back(3'd7);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (halted_m) done = 1'b1;
      else cyc(1'b1, 1'b0);
    end
    if (!done) check("timeout_halt", 32'd1, 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'(i % 2), 1'b0);
    check("halted_pin", 32'(halted), 32'd1);
    cyc(1'b0, 1'b1);
    check("halted_cleared", 32'(halted), 32'd0);
    cyc(1'b0, 1'b0);

    // STO interrupted by reset while in EX.
    op_q.push_back(3'd3);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cur_op == 3'd3 && exp_q.size() == 1) done = 1'b1;
      else cyc(1'b1, 1'b0);
    end
    if (!done) check("timeout_sto_ex", 32'd1, 32'd0);
    check("sto_ex_ram_wr", 32'(ram_wr), 32'd1);
    cyc(1'b1, 1'b1);

    // Random opcodes, en and occasional resets.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ins_ctrl.md
INS_CTRL -- requirements
Module: ins_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-low; state and outputs cleared while low.
REQ-003 en  input  1  run enable; sampled only in IDLE and at the end of each instruction.
REQ-004 ins  input  3  opcode from the instruction register; valid from the cycle after fetch=2'b01.
REQ-005 fetch  output  2  2'b01 loads the opcode byte; 2'b10 loads the operand byte; 2'b00 holds.
REQ-006 pc_ena  output  1  increment the program counter at the end of this cycle.
REQ-007 addr_sel  output  1  0: memory address from the PC; 1: memory address from the operand byte.
REQ-008 rom_sel  output  1  ROM drives the data bus.
REQ-009 ram_sel, ram_rd, ram_wr  output  1 each  RAM select, read, and write strobe.
REQ-010 reg_rd, reg_wr  output  1 each  register file read or write at the opcode register address.
REQ-011 reg_src  output  1  register write source; 0: data bus; 1: accumulator.
REQ-012 alu_ena, acc_ena  output  1 each  ALU add enable and accumulator load enable.
REQ-013 halted  output  1  high while in HALT.

Function
REQ-014 Opcodes SHALL be: NOP 000, LDO 001, LDA 010, STO 011, PRE 100, ADD 101, LDM 110, HLT 111.
REQ-015 States SHALL be IDLE, F1, DEC, F2, EX, HALT; binary encoding.
REQ-016 Outputs SHALL be a function of the current state and ins only; every output not listed for a state is 0.
REQ-017 IDLE: all outputs 0; next state F1 if en=1, else IDLE.
REQ-018 F1: fetch=01, rom_sel=1, pc_ena=1, addr_sel=0; next state DEC unconditionally.
REQ-019 DEC: all outputs 0; next state F2 for two-byte opcodes (001, 010, 011, 100); otherwise EX.
REQ-020 F2: fetch=10, rom_sel=1, pc_ena=1, addr_sel=0; next state EX.
REQ-021 EX outputs by opcode:
- NOP: none.
- LDO: addr_sel, rom_sel, reg_wr (reg_src=0).
- LDA: addr_sel, ram_sel, ram_rd, reg_wr (reg_src=0).
- STO: addr_sel, reg_rd, ram_sel, ram_wr.
- PRE: addr_sel, rom_sel, acc_ena.
- ADD: reg_rd, alu_ena, acc_ena.
- LDM: reg_wr, reg_src=1.
- HLT: none.
REQ-022 EX next state: HALT for HLT; otherwise F1 if en=1, else IDLE.
REQ-023 HALT: halted=1, all other outputs 0; HALT SHALL be left only by reset, regardless of en.
REQ-024 Instruction latency, F1 to last EX cycle: 3 cycles for one-byte instructions and 4 cycles for two-byte instructions; back-to-back instructions have no gap while en=1.
REQ-025 fetch SHALL never be 2'b11; ram_rd and ram_wr SHALL never both be 1; rom_sel and ram_sel SHALL never both be 1.
REQ-026 en falling mid-instruction SHALL NOT abort it; the instruction completes through EX, then the block enters IDLE.
REQ-027 pc_ena SHALL pulse exactly once per fetched byte: 1 per one-byte and 2 per two-byte instruction.

Reset
REQ-028 rst low SHALL force IDLE immediately, asynchronously, from any state including F2, EX, and HALT; all outputs go to 0.
REQ-029 After rst rises, the first F1 SHALL occur on the first rising edge with en=1.
REQ-030 A reset during EX SHALL cancel any pending ram_wr or reg_wr in the same instant that rst falls.

Verification
REQ-031 Reset release with en=1, opcode NOP -> states F1, DEC, EX, F1; fetch sequence 01, 00, 00, 01; one pc_ena pulse.
REQ-032 LDA (ins=010), en=1 -> F1, DEC, F2, EX; fetch 01, 00, 10, 00; in EX: addr_sel=1, ram_rd=1, reg_wr=1, ram_wr=0; two pc_ena pulses.
REQ-033 STO then ADD back-to-back -> EX(STO) shows ram_wr=1, reg_rd=1; the next cycle is F1; EX(ADD) shows alu_ena=1, acc_ena=1, reg_wr=0.
REQ-034 en dropped during F2 of PRE -> EX completes with acc_ena=1, then IDLE; holding en=0 for 5 cycles produces no fetch and no pc_ena.
REQ-035 HLT (ins=111) -> EX, then HALT with halted=1; toggling en for 10 cycles produces no change; rst pulse -> IDLE and halted=0.
REQ-036 rst asserted mid-EX of STO -> ram_wr drops without waiting for a clock edge; every cycle checks the mutual-exclusion rules of REQ-025.
